// File: rtl/mycpu_pkg.sv
// mycpu shared definitions: opcodes, control-unit states and datapath select encodings.
package mycpu_pkg;

  localparam int unsigned OPC_W = 7;

  // Instruction opcodes of the mycpu ISA.
  typedef enum logic [6:0] {
    OP_MOVA = 7'b0000000,
    OP_INC  = 7'b0000001,
    OP_ADD  = 7'b0000010,
    OP_SUB  = 7'b0000101,
    OP_DEC  = 7'b0000110,
    OP_AND  = 7'b0001000,
    OP_OR   = 7'b0001001,
    OP_XOR  = 7'b0001010,
    OP_NOT  = 7'b0001011,
    OP_MOVB = 7'b0001100,
    OP_SHR  = 7'b0001101,
    OP_SHL  = 7'b0001110,
    OP_LD   = 7'b0010000,
    OP_IOR  = 7'b0010001,
    OP_ST   = 7'b0100000,
    OP_IOW  = 7'b0100001,
    OP_ADI  = 7'b1000010,
    OP_LDI  = 7'b1001100,
    OP_BRZ  = 7'b1100000,
    OP_BRN  = 7'b1100001,
    OP_JMP  = 7'b1110000,
    OP_HAL  = 7'b1111000
  } opcode_t;

  // Multi-cycle control unit states.
  localparam int unsigned CU_MC_SW = 3;
  typedef logic [CU_MC_SW-1:0] cu_mc_state_t;
  localparam cu_mc_state_t ST_RST = 3'd0;
  localparam cu_mc_state_t ST_INF = 3'd1;
  localparam cu_mc_state_t ST_EX0 = 3'd2;
  localparam cu_mc_state_t ST_HLT = 3'd3;
  localparam cu_mc_state_t ST_ERR = 3'd4;

  // PC select encodings.
  typedef logic [1:0] ps_t;
  localparam ps_t PS_HOLD = 2'b00;
  localparam ps_t PS_INC  = 2'b01;
  localparam ps_t PS_BR   = 2'b10;
  localparam ps_t PS_JMP  = 2'b11;

  // Destination data mux encodings.
  typedef logic [1:0] md_t;
  localparam md_t MD_FU  = 2'b00;
  localparam md_t MD_MEM = 2'b01;
  localparam md_t MD_IO  = 2'b10;

  // True for opcodes that use the memory/IO ready handshake.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_IOR) || (op == OP_IOW);
  endfunction

  // True for any encoding that is a member of opcode_t.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    logic ok;
    case (op)
      OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_LD, OP_IOR, OP_ST, OP_IOW,
      OP_ADI, OP_LDI, OP_BRZ, OP_BRN, OP_JMP, OP_HAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cu_mc_wdog.sv
// Bus-timeout watchdog: counts consecutive not-ready cycles of an active access.
// MEM_TO = 0 removes the counter and never expires.
module cu_mc_wdog #(
  parameter int unsigned MEM_TO = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic rdy_i,
  output logic expire_c_o
);

  localparam int unsigned CW = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

  generate
    if (MEM_TO == 0) begin : g_off
      assign expire_c_o = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Expire on the last allowed not-ready cycle.
      assign expire_c_o = active_i && !rdy_i && (cnt_q == CW'(MEM_TO - 1));

      // Count while waiting; any ready, idle or expiry restarts from zero.
      always_comb begin
        cnt_d = '0;
        if (active_i && !rdy_i && !expire_c_o) cnt_d = cnt_q + CW'(1);
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit for the mycpu datapath: fetch/execute sequencing with
// memory/IO wait states, bus-timeout watchdog and illegal-opcode error state.
// Optional interrupt entry (irq_in / irq_ack_out) is enabled by defining CU_MC_IRQ_EN.
module cu_mc
  import mycpu_pkg::*;
#(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned MEM_TO = 16,
  localparam int unsigned IW = 7 + 3 * REG_AW,
  localparam int unsigned FW = REG_AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   ins_in,
  input  logic            z_in,
  input  logic            n_in,
  input  logic            mem_rdy_in,
`ifdef CU_MC_IRQ_EN
  input  logic            irq_in,
  output logic            irq_ack_out,
`endif
  output logic            il_out,
  output logic [1:0]      ps_out,
  output logic            rw_out,
  output logic [3*FW-1:0] rs_out,
  output logic            mm_out,
  output logic [1:0]      md_out,
  output logic            mb_out,
  output logic [3:0]      fs_out,
  output logic            wen_out,
  output logic            iom_out,
  output logic            err_out
);

  cu_mc_state_t state_q;
  cu_mc_state_t state_d;

  logic [OPC_W-1:0]  op;
  logic [REG_AW-1:0] f_d;
  logic [REG_AW-1:0] f_a;
  logic [REG_AW-1:0] f_b;
  logic              op_legal;
  logic              op_mem;
  logic              op_io;
  logic              op_wr;
  logic              wd_active;
  logic              wd_expire;
  logic              irq_ack_c;

  // Instruction field split and opcode classification.
  assign op       = ins_in[IW-1 -: OPC_W];
  assign f_d      = ins_in[3*REG_AW-1 -: REG_AW];
  assign f_a      = ins_in[2*REG_AW-1 -: REG_AW];
  assign f_b      = ins_in[REG_AW-1:0];
  assign op_legal = is_legal_op(op);
  assign op_mem   = op_legal && is_mem_op(opcode_t'(op));
  assign op_io    = (op == OP_IOR) || (op == OP_IOW);
  assign op_wr    = (op == OP_ST)  || (op == OP_IOW);

`ifdef CU_MC_IRQ_EN
  logic fetch_busy_q;
  logic fetch_busy_d;

  // Ack only before the fetch has started, or to wake from halt.
  assign irq_ack_c    = irq_in && (((state_q == ST_INF) && !fetch_busy_q) || (state_q == ST_HLT));
  assign irq_ack_out  = irq_ack_c;
  assign fetch_busy_d = (state_d == ST_INF) && (irq_ack_c || (state_q == ST_INF));

  // Marks that the current INF visit is past its interrupt window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_busy_q <= 1'b0;
    else        fetch_busy_q <= fetch_busy_d;
  end
`else
  assign irq_ack_c = 1'b0;
`endif

  // Watchdog covers fetch and memory-op execute; the ack cycle is not an access.
  assign wd_active = ((state_q == ST_INF) && !irq_ack_c) || ((state_q == ST_EX0) && op_mem);

  cu_mc_wdog #(
    .MEM_TO(MEM_TO)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (wd_active),
    .rdy_i     (mem_rdy_in),
    .expire_c_o(wd_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  // Next-state and control decode; everything idles unless a branch below drives it.
  always_comb begin
    state_d = state_q;
    il_out  = 1'b0;
    ps_out  = PS_HOLD;
    rw_out  = 1'b0;
    rs_out  = '0;
    mm_out  = 1'b0;
    md_out  = MD_FU;
    mb_out  = 1'b0;
    fs_out  = 4'b0000;
    wen_out = 1'b1;
    iom_out = 1'b0;
    err_out = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_INF;

      ST_INF: begin
        if (irq_ack_c) begin
          state_d = ST_INF;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end else begin
          il_out = mem_rdy_in;
          if (mem_rdy_in) state_d = ST_EX0;
        end
      end

      ST_EX0: begin
        if (!op_legal) begin
          state_d = ST_ERR;
        end else if (op_mem) begin
          rs_out  = {1'b0, f_d, 1'b0, f_a, 1'b0, f_b};
          mm_out  = 1'b1;
          iom_out = op_io;
          md_out  = (op == OP_LD) ? MD_MEM : ((op == OP_IOR) ? MD_IO : MD_FU);
          wen_out = !op_wr;
          if (wd_expire) begin
            state_d = ST_ERR;
          end else if (mem_rdy_in) begin
            ps_out  = PS_INC;
            rw_out  = !op_wr;
            state_d = ST_INF;
          end
        end else begin
          rs_out = {1'b0, f_d, 1'b0, f_a, 1'b0, f_b};
          mb_out = (op == OP_LDI) || (op == OP_ADI);
          case (op)
            OP_BRZ: ps_out = z_in ? PS_BR : PS_INC;
            OP_BRN: ps_out = n_in ? PS_BR : PS_INC;
            OP_JMP: ps_out = PS_JMP;
            OP_HAL: ps_out = PS_HOLD;
            default: ps_out = PS_INC;
          endcase
          rw_out = !((op == OP_BRZ) || (op == OP_BRN) || (op == OP_JMP) || (op == OP_HAL));
          fs_out = ((op == OP_BRZ) || (op == OP_BRN) || (op == OP_JMP)) ? 4'b0000 : op[3:0];
          state_d = (op == OP_HAL) ? ST_HLT : ST_INF;
        end
      end

      ST_HLT: begin
        if (irq_ack_c) state_d = ST_INF;
      end

      ST_ERR: err_out = 1'b1;

      default: state_d = ST_ERR;
    endcase
  end

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc (REG_AW=3, MEM_TO=4); interrupt checks need CU_MC_IRQ_EN.
module tb_cu_mc;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins;
  logic        z, n, rdy;
  logic        il, rw, mm, mb, wen, iom, err;
  logic [1:0]  ps, md;
  logic [11:0] rs;
  logic [3:0]  fs;
  int          total = 0;
  int          bad = 0;
`ifdef CU_MC_IRQ_EN
  logic        irq;
  logic        ack;
`endif

  always #5 clk = ~clk;

  cu_mc #(.REG_AW(3), .MEM_TO(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_in    (ins),
    .z_in      (z),
    .n_in      (n),
    .mem_rdy_in(rdy),
`ifdef CU_MC_IRQ_EN
    .irq_in    (irq),
    .irq_ack_out(ack),
`endif
    .il_out    (il),
    .ps_out    (ps),
    .rw_out    (rw),
    .rs_out    (rs),
    .mm_out    (mm),
    .md_out    (md),
    .mb_out    (mb),
    .fs_out    (fs),
    .wen_out   (wen),
    .iom_out   (iom),
    .err_out   (err)
  );

  function automatic logic [15:0] mk(input opcode_t o, input int d, input int a, input int b);
    return {o, 3'(d), 3'(a), 3'(b)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Compare the whole output bundle against a hand-computed vector.
  task automatic chk(input string tag, input logic e_il, input logic [1:0] e_ps, input logic e_rw,
                     input logic [11:0] e_rs, input logic e_mm, input logic [1:0] e_md, input logic e_mb,
                     input logic [3:0] e_fs, input logic e_wen, input logic e_iom, input logic e_err);
    logic [26:0] obs;
    logic [26:0] exp;
    #1;
    obs = {il, ps, rw, rs, mm, md, mb, fs, wen, iom, err};
    exp = {e_il, e_ps, e_rw, e_rs, e_mm, e_md, e_mb, e_fs, e_wen, e_iom, e_err};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (il ps rw rs mm md mb fs wen iom err)", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0);
  endtask

  task automatic chk_fetch(input string tag);
    chk(tag, 1, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0);
  endtask

  task automatic chk_err(input string tag);
    chk(tag, 0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 1);
  endtask

`ifdef CU_MC_IRQ_EN
  task automatic chk_ack(input string tag, input logic e_ack);
    #1;
    total++;
    assert (ack === e_ack) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, ack, e_ack);
    end
  endtask
`endif

  initial begin
    #60000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; z = 1'b0; n = 1'b0;
    ins = mk(OP_ADI, 1, 2, 5);
`ifdef CU_MC_IRQ_EN
    irq = 1'b0;
`endif
    #3 chk_idle("reset_idle");
    @(negedge clk); rst_n = 1'b1;

    // ADI fetch/execute loop with ready always high
    tick; chk_fetch("adi_fetch");
    tick; chk("adi_ex", 0, 2'b01, 1, 12'h125, 0, 2'b00, 1, 4'h2, 1, 0, 0);
    tick; chk_fetch("adi_loop_fetch");

    // ST with three wait cycles
    ins = mk(OP_ST, 0, 3, 4);
    tick; rdy = 1'b0; chk("st_wait0", 0, 2'b00, 0, 12'h034, 1, 2'b00, 0, 4'h0, 0, 0, 0);
    tick; chk("st_wait1", 0, 2'b00, 0, 12'h034, 1, 2'b00, 0, 4'h0, 0, 0, 0);
    tick; chk("st_wait2", 0, 2'b00, 0, 12'h034, 1, 2'b00, 0, 4'h0, 0, 0, 0);
    tick; rdy = 1'b1; chk("st_done", 0, 2'b01, 0, 12'h034, 1, 2'b00, 0, 4'h0, 0, 0, 0);
    tick; chk_fetch("st_after_fetch");

    // Branches and jump (jump with ready low: ready is ignored there)
    ins = mk(OP_BRZ, 0, 0, 0); z = 1'b1;
    tick; chk("brz_taken", 0, 2'b10, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0);
    tick; chk_fetch("brz_fetch2"); z = 1'b0;
    tick; chk("brz_not_taken", 0, 2'b01, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0);
    tick; ins = mk(OP_BRN, 0, 0, 0); n = 1'b1; chk_fetch("brn_fetch");
    tick; chk("brn_taken", 0, 2'b10, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0);
    tick; ins = mk(OP_JMP, 0, 5, 0); n = 1'b0; chk_fetch("jmp_fetch");
    tick; rdy = 1'b0; chk("jmp_ex", 0, 2'b11, 0, 12'h050, 0, 2'b00, 0, 4'h0, 1, 0, 0);
    tick; rdy = 1'b1; chk_fetch("jmp_after_fetch");

    // LD / IOR complete immediately
    ins = mk(OP_LD, 2, 6, 0);
    tick; chk("ld_ex", 0, 2'b01, 1, 12'h260, 1, 2'b01, 0, 4'h0, 1, 0, 0);
    tick; ins = mk(OP_IOR, 7, 1, 0); chk_fetch("ior_fetch");
    tick; chk("ior_ex", 0, 2'b01, 1, 12'h710, 1, 2'b10, 0, 4'h0, 1, 1, 0);
    tick; ins = mk(OP_IOW, 0, 4, 3); chk_fetch("iow_fetch");
    tick; rdy = 1'b0; chk("iow_wait", 0, 2'b00, 0, 12'h043, 1, 2'b00, 0, 4'h0, 0, 1, 0);
    tick; rdy = 1'b1; chk("iow_done", 0, 2'b01, 0, 12'h043, 1, 2'b00, 0, 4'h0, 0, 1, 0);
    tick; ins = mk(OP_LDI, 6, 0, 7); chk_fetch("ldi_fetch");
    tick; chk("ldi_ex", 0, 2'b01, 1, 12'h607, 0, 2'b00, 1, 4'hC, 1, 0, 0);

    // Fetch timeout: four not-ready cycles in INF, then ERR
    tick; rdy = 1'b0; chk_idle("to_inf1");
    tick; chk_idle("to_inf2");
    tick; chk_idle("to_inf3");
    tick; chk_idle("to_inf4");
    tick; chk_err("to_err");
    rdy = 1'b1;
    tick; chk_err("err_sticky");
    #2 rst_n = 1'b0;
    chk_idle("async_reset_clears_err");
    @(negedge clk); rst_n = 1'b1;

    // Undefined opcode goes to ERR without strobes
    tick; ins = {7'b0000011, 9'd0}; chk_fetch("undef_fetch");
    tick; chk_idle("undef_ex");
    tick; chk_err("undef_err");
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Halt holds everything idle
    tick; ins = mk(OP_HAL, 0, 0, 0); chk_fetch("hal_fetch");
    tick; chk("hal_ex", 0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h8, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick; chk_idle($sformatf("hlt_idle%0d", i));
    end

`ifdef CU_MC_IRQ_EN
    // Interrupt at fetch entry, then from halt
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick; irq = 1'b1; chk_idle("irq_inf_outputs"); chk_ack("irq_inf_ack", 1'b1);
    tick; chk_fetch("irq_then_fetch"); chk_ack("irq_single_pulse", 1'b0);
    tick; irq = 1'b0; chk("irq_hal_ex", 0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h8, 1, 0, 0);
    tick; chk_ack("irq_hlt_no_ack", 1'b0);
    irq = 1'b1; chk_idle("irq_hlt_outputs"); chk_ack("irq_hlt_ack", 1'b1);
    tick; chk_fetch("irq_hlt_to_fetch"); chk_ack("irq_hlt_ack_done", 1'b0);
    irq = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
